video_pll_ctrl: RTL

//  Mode sequencer for a Gowin rPLL running with dynamic dividers (DYN_*_SEL="true").

---
 rtl/video_pll_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/video_pll_ctrl.sv
// ============================================================================
// Module      : video_pll_ctrl
// Description : Mode sequencer for a Gowin rPLL with dynamic dividers. It applies
//               the IDSEL/FBDSEL/ODSEL values for a mode, pulses RESET, and waits
//               for a stable lock with timeout and retry. It holds video_rst until
//               the PLL is locked.
//               Optional feature: VIDEO_PLL_LOL_RECOVER_EN (automatic relock on loss of lock)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_pll_ctrl #(
  parameter int unsigned              NUM_MODES    = 4,
  parameter int unsigned              MODE_W       = 2,
  parameter logic [NUM_MODES*6-1:0]   IDIV_TABLE   = {6'd3, 6'd2, 6'd0, 6'd1},
  parameter logic [NUM_MODES*6-1:0]   FBDIV_TABLE  = {6'd36, 6'd10, 6'd54, 6'd9},
  parameter logic [NUM_MODES*6-1:0]   ODIV_TABLE   = {6'd2, 6'd4, 6'd16, 6'd8},
  parameter int unsigned              RST_CYCLES   = 16,
  parameter int unsigned              LOCK_TIMEOUT = 27000,
  parameter int unsigned              LOCK_STABLE  = 256,
  parameter int unsigned              MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] i_mode_req,
  input  logic              i_mode_req_valid,
  output logic              o_mode_req_ready,
  input  logic              i_pll_lock,
  output logic              o_pll_reset,
  output logic [5:0]        o_pll_idsel,
  output logic [5:0]        o_pll_fbdsel,
  output logic [5:0]        o_pll_odsel,
  output logic [MODE_W-1:0] o_mode_cur,
  output logic              o_locked,
  output logic              o_video_rst,
  output logic              o_fail,
  output logic [1:0]        o_retry_cnt
);

  localparam int unsigned C_RCW = $clog2(RST_CYCLES);
  localparam int unsigned C_TMW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned C_STW = $clog2(LOCK_STABLE + 1);
  localparam logic [C_RCW-1:0] C_RST_LAST = C_RCW'(RST_CYCLES - 2);
  localparam logic [C_TMW-1:0] C_TMO_LAST = C_TMW'(LOCK_TIMEOUT - 1);
  localparam logic [C_STW-1:0] C_STB_LAST = C_STW'(LOCK_STABLE - 1);

  typedef enum logic [2:0] {
    S_APPLY     = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_lock_s1;
  logic               r_lock_s2;
  logic [MODE_W-1:0]  r_target;
  logic [MODE_W-1:0]  r_mode_cur;
  logic [5:0]         r_idsel;
  logic [5:0]         r_fbdsel;
  logic [5:0]         r_odsel;
  logic [1:0]         r_retry;
  logic [C_RCW-1:0]   r_rst_cnt;
  logic [C_TMW-1:0]   r_timer;
  logic [C_STW-1:0]   r_stable_cnt;
  logic               w_ready;
  logic               w_accept;
  logic               w_retry;
  logic [5:0]         w_idiv;
  logic [5:0]         w_fbdiv;
  logic [5:0]         w_odiv;

  assign w_ready  = (r_state == S_RUN) || (r_state == S_FAIL);
  // Out-of-range requests are consumed by the handshake but never reach the FSM.
  assign w_accept = i_mode_req_valid && w_ready && (32'(i_mode_req) < NUM_MODES);

  always_comb begin
    w_idiv  = IDIV_TABLE[5:0];
    w_fbdiv = FBDIV_TABLE[5:0];
    w_odiv  = ODIV_TABLE[5:0];
    for (int m = 0; m < int'(NUM_MODES); m++) begin
      if (r_target == MODE_W'(m)) begin
        w_idiv  = IDIV_TABLE[6*m +: 6];
        w_fbdiv = FBDIV_TABLE[6*m +: 6];
        w_odiv  = ODIV_TABLE[6*m +: 6];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_APPLY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_retry = 1'b0;
    case (r_state)
      S_APPLY: w_next = S_RESET;
      S_RESET: begin
        if (r_rst_cnt == C_RST_LAST) w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (r_lock_s2) begin
          w_next = S_STABLE;
        end else if (r_timer == C_TMO_LAST) begin
          if ((32'(r_retry) < MAX_RETRY) && (r_retry != 2'd3)) begin
            w_retry = 1'b1;
            w_next  = S_APPLY;
          end else begin
            w_next = S_FAIL;
          end
        end
      end
      S_STABLE: begin
        if (!r_lock_s2) w_next = S_WAIT_LOCK;
        else if (r_stable_cnt == C_STB_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_accept) w_next = S_APPLY;
`ifdef VIDEO_PLL_LOL_RECOVER_EN
        else if (!r_lock_s2) w_next = S_APPLY;
`else
        // Loss of lock is only recorded; RUN is held until a new request.
`endif
      end
      S_FAIL: begin
        if (w_accept) w_next = S_APPLY;
      end
      default: w_next = S_APPLY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_s1    <= 1'b0;
      r_lock_s2    <= 1'b0;
      r_target     <= '0;
      r_mode_cur   <= '0;
      r_idsel      <= 6'd63 - IDIV_TABLE[5:0];
      r_fbdsel     <= 6'd63 - FBDIV_TABLE[5:0];
      r_odsel      <= ODIV_TABLE[5:0];
      r_retry      <= 2'd0;
      r_rst_cnt    <= '0;
      r_timer      <= '0;
      r_stable_cnt <= '0;
    end else begin
      r_lock_s1 <= i_pll_lock;
      r_lock_s2 <= r_lock_s1;
      case (r_state)
        S_APPLY: begin
          r_mode_cur <= r_target;
          r_idsel    <= 6'd63 - w_idiv;
          r_fbdsel   <= 6'd63 - w_fbdiv;
          r_odsel    <= w_odiv;
          r_rst_cnt  <= '0;
        end
        S_RESET: begin
          if (r_rst_cnt != C_RST_LAST) r_rst_cnt <= r_rst_cnt + C_RCW'(1);
          r_timer <= '0;
        end
        S_WAIT_LOCK: begin
          r_stable_cnt <= '0;
          if (r_timer != C_TMO_LAST) r_timer <= r_timer + C_TMW'(1);
          if (w_retry) r_retry <= r_retry + 2'd1;
        end
        S_STABLE: begin
          if (r_lock_s2 && (r_stable_cnt != C_STB_LAST)) r_stable_cnt <= r_stable_cnt + C_STW'(1);
        end
        default: ;
      endcase
      if (w_accept) r_target <= i_mode_req;
      // Every new sequence started from RUN or FAIL begins with a fresh retry budget.
      if (w_ready && (w_next == S_APPLY)) r_retry <= 2'd0;
    end
  end

`ifdef VIDEO_PLL_LOL_RECOVER_EN
  // Loss of lock re-enters APPLY directly; no sticky flag is needed.
`else
  logic r_lol;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lol <= 1'b0;
    end else if (w_accept) begin
      r_lol <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_lol <= r_lol | ~r_lock_s2;
    end
  end
`endif

  assign o_mode_req_ready = w_ready;
  assign o_pll_reset      = (r_state == S_APPLY) || (r_state == S_RESET);
  assign o_pll_idsel      = r_idsel;
  assign o_pll_fbdsel     = r_fbdsel;
  assign o_pll_odsel      = r_odsel;
  assign o_mode_cur       = r_mode_cur;
  assign o_locked         = (r_state == S_RUN);
  assign o_video_rst      = (r_state != S_RUN);
  assign o_fail           = (r_state == S_FAIL);
  assign o_retry_cnt      = r_retry;

endmodule

`default_nettype wire
